// File: rtl/servo_pkg.sv
// Shared types, widths and default timing constants for the servo position
// controller and the PWM generator it drives.
package servo_pkg;

    localparam int DUTY_W  = 18;
    localparam int CNT_W   = 20;
    localparam int ANGLE_W = 8;

    localparam int unsigned DEF_CLK_IN     = 50_000_000;
    localparam int unsigned DEF_FREQ_SERVO = 50;
    localparam int unsigned DEF_MIN_PULSE  = 50_000;
    localparam int unsigned DEF_MAX_PULSE  = 100_000;
    localparam int unsigned DEF_LSB_CYCLES = 196;
    localparam int unsigned DEF_STEP       = 2_500;

    typedef enum logic [1:0] {OFF, HOLD, RAMP} servo_state_t;

    // Angle code to pulse width; 32-bit intermediate so large codes clamp
    // instead of wrapping.
    function automatic logic [DUTY_W-1:0] map_angle(
        input logic [ANGLE_W-1:0] angle,
        input int unsigned        min_pulse,
        input int unsigned        lsb_cycles,
        input int unsigned        max_pulse
    );
        logic [31:0] pos;
        pos = min_pulse + 32'(angle) * lsb_cycles;
        if (pos > max_pulse)
            pos = max_pulse;
        return pos[DUTY_W-1:0];
    endfunction

    function automatic logic [DUTY_W-1:0] step_toward(
        input logic [DUTY_W-1:0] duty,
        input logic [DUTY_W-1:0] target,
        input logic [DUTY_W-1:0] step
    );
        if (duty < target)
            return (target - duty > step) ? duty + step : target;
        else
            return (duty - target > step) ? duty - step : target;
    endfunction

endpackage

// File: rtl/servo_frame_timer.sv
// Free-running frame counter; frame_tick marks the last cycle of each
// servo frame.
module servo_frame_timer
    import servo_pkg::*;
#(
    parameter int unsigned TOTAL_PERIOD = DEF_CLK_IN / DEF_FREQ_SERVO
) (
    input  logic clk,
    input  logic rst,
    output logic frame_tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL_PERIOD - 1);

    logic [CNT_W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // in the design updates from pre-edge values, independent of block order.
    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (count == LAST)
            count <= '0;
        else
            count <= count + CNT_W'(1);
    end

    assign frame_tick = (count == LAST);

endmodule

// File: rtl/servo_ctrl.sv
// Servo position controller: accepts angle commands, maps them to pulse
// widths and slews duty by at most STEP per frame, only at frame boundaries.
module servo_ctrl
    import servo_pkg::*;
#(
    parameter int unsigned CLK_IN     = DEF_CLK_IN,
    parameter int unsigned FREQ_SERVO = DEF_FREQ_SERVO,
    parameter int unsigned MIN_PULSE  = DEF_MIN_PULSE,
    parameter int unsigned MAX_PULSE  = DEF_MAX_PULSE,
    parameter int unsigned LSB_CYCLES = DEF_LSB_CYCLES,
    parameter int unsigned STEP       = DEF_STEP
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [ANGLE_W-1:0] cmd_angle,
    output logic [DUTY_W-1:0]  duty,
    output logic               frame_tick,
    output logic               at_target,
    output logic               busy
);

    localparam int unsigned       TOTAL_PERIOD = CLK_IN / FREQ_SERVO;
    localparam logic [DUTY_W-1:0] MIN_POS      = DUTY_W'(MIN_PULSE);
    localparam logic [DUTY_W-1:0] STEP_D       = DUTY_W'(STEP);

    servo_state_t      state, state_next;
    logic [DUTY_W-1:0] duty_next;
    logic [DUTY_W-1:0] pending, target, target_in;
    logic              pending_full;
    logic              accept, transfer;

    servo_frame_timer #(
        .TOTAL_PERIOD(TOTAL_PERIOD)
    ) u_frame_timer (
        .clk       (clk),
        .rst       (rst),
        .frame_tick(frame_tick)
    );

    assign cmd_ready = !rst && !pending_full;
    assign accept    = cmd_valid && cmd_ready;
    assign transfer  = frame_tick && pending_full;
    // A transfer on this tick steers the step calculation immediately.
    assign target_in = transfer ? pending : target;

    // Accept and transfer are exclusive: the slot is never ready while full,
    // so a command accepted on a tick waits for the following tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_full <= 1'b0;
            pending      <= '0;
            target       <= MIN_POS;
        end else begin
            if (transfer) begin
                target       <= pending;
                pending_full <= 1'b0;
            end
            if (accept) begin
                pending      <= map_angle(cmd_angle, MIN_PULSE, LSB_CYCLES, MAX_PULSE);
                pending_full <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= OFF;
            duty  <= '0;
        end else begin
            state <= state_next;
            duty  <= duty_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        duty_next  = duty;
        if (frame_tick) begin
            if (!enable) begin
                state_next = OFF;
                duty_next  = '0;
            end else begin
                unique case (state)
                    OFF: begin
                        // Mechanical position is unknown after power-up: jump, do not slew.
                        state_next = HOLD;
                        duty_next  = target_in;
                    end
                    HOLD, RAMP: begin
                        duty_next  = step_toward(duty, target_in, STEP_D);
                        state_next = (duty_next == target_in) ? HOLD : RAMP;
                    end
                    default: begin
                        state_next = OFF;
                        duty_next  = '0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        busy      = (state == RAMP);
        at_target = (state == HOLD) && (duty == target);
    end

endmodule

// File: tb/tb_servo_ctrl.sv
// Bench for servo_ctrl with shortened frame timing; directed scenarios
// followed by random stimulus against a per-frame behavioural model.
module tb_servo_ctrl;
    import servo_pkg::*;

    localparam int unsigned P_CLK  = 1000;
    localparam int unsigned P_FREQ = 10;
    localparam int          P      = 100;
    localparam int          MINP   = 20;
    localparam int          MAXP   = 80;
    localparam int          LSB    = 1;
    localparam int          STP    = 10;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               enable = 1'b0;
    logic               cmd_valid = 1'b0;
    logic [ANGLE_W-1:0] cmd_angle = '0;
    logic               cmd_ready;
    logic [DUTY_W-1:0]  duty;
    logic               frame_tick;
    logic               at_target;
    logic               busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Model: frame position, latched power state, duty, target, pending slot.
    int m_cnt    = 0;
    int m_duty   = 0;
    int m_target = MINP;
    int m_pend   = 0;
    bit m_pend_v = 1'b0;
    bit m_on     = 1'b0;

    servo_ctrl #(
        .CLK_IN    (P_CLK),
        .FREQ_SERVO(P_FREQ),
        .MIN_PULSE (MINP),
        .MAX_PULSE (MAXP),
        .LSB_CYCLES(LSB),
        .STEP      (STP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_angle (cmd_angle),
        .duty      (duty),
        .frame_tick(frame_tick),
        .at_target (at_target),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic int m_map(input int a);
        int p;
        p = MINP + a * LSB;
        return (p > MAXP) ? MAXP : p;
    endfunction

    function automatic int m_move(input int d, input int t);
        if (d < t) return (d + STP > t) ? t : d + STP;
        return (d - STP < t) ? t : d - STP;
    endfunction

    // One clock: advance the model on the edge, return at the falling edge.
    task automatic step();
        bit tick, acc;
        @(posedge clk);
        tick = (m_cnt == P - 1);
        acc  = cmd_valid && !rst && !m_pend_v;
        if (rst) begin
            m_cnt = 0; m_duty = 0; m_target = MINP; m_pend_v = 1'b0; m_on = 1'b0;
        end else begin
            if (tick) begin
                if (m_pend_v) begin
                    m_target = m_pend;
                    m_pend_v = 1'b0;
                end
                if (!enable) begin
                    m_on = 1'b0; m_duty = 0;
                end else if (!m_on) begin
                    m_on = 1'b1; m_duty = m_target;
                end else begin
                    m_duty = m_move(m_duty, m_target);
                end
            end
            if (acc) begin
                m_pend   = m_map(int'(cmd_angle));
                m_pend_v = 1'b1;
            end
            m_cnt = tick ? 0 : m_cnt + 1;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1; enable = 1'b0; cmd_valid = 1'b0;
        repeat (n) step();
        rst = 1'b0;
        cyc = 0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (duty !== '0)      begin n_err++; $display("FAIL rst_duty: got %0d want 0", duty); end
            n_cmp++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b want 0", cmd_ready); end
            n_cmp++; if (frame_tick !== 1'b0) begin n_err++; $display("FAIL rst_tick: got %b want 0", frame_tick); end
            n_cmp++; if (at_target !== 1'b0) begin n_err++; $display("FAIL rst_at_target: got %b want 0", at_target); end
            n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
        end
        rst = 1'b0;
        cyc = 0;
        #1;
        n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL release_ready: got %b want 1", cmd_ready); end
        n_cmp++; if (frame_tick !== 1'b0) begin n_err++; $display("FAIL release_tick: got %b want 0", frame_tick); end
        while (cyc < 200) begin
            step();
            n_cmp++;
            if (frame_tick !== (cyc == 99 || cyc == 199)) begin
                n_err++; $display("FAIL tick_position: cycle %0d got %b", cyc, frame_tick);
            end
        end
        n_cmp++; if (duty !== '0) begin n_err++; $display("FAIL disabled_duty: got %0d want 0", duty); end
    endtask

    task automatic test_first_enable();
        do_reset(2);
        enable = 1'b1;
        run_to(5);
        cmd_valid = 1'b1; cmd_angle = 8'd30;
        step();
        cmd_valid = 1'b0;
        n_cmp++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL first_pending_ready: got %b want 0", cmd_ready); end
        run_to(99);
        n_cmp++; if (frame_tick !== 1'b1) begin n_err++; $display("FAIL first_tick: got %b want 1", frame_tick); end
        n_cmp++; if (duty !== '0) begin n_err++; $display("FAIL first_pre_duty: got %0d want 0", duty); end
        run_to(100);
        n_cmp++; if (duty !== 18'd50) begin n_err++; $display("FAIL first_duty: got %0d want 50", duty); end
        n_cmp++; if (at_target !== 1'b1) begin n_err++; $display("FAIL first_at_target: got %b want 1", at_target); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL first_busy: got %b want 0", busy); end
        n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL first_ready_back: got %b want 1", cmd_ready); end
    endtask

    task automatic test_down_ramp();
        int exp_duty [3] = '{40, 30, 20};
        cmd_valid = 1'b1; cmd_angle = 8'd0;
        step();
        cmd_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            run_to(200 + 100 * k);
            n_cmp++; if (duty !== DUTY_W'(exp_duty[k])) begin n_err++; $display("FAIL ramp_duty: cycle %0d got %0d want %0d", cyc, duty, exp_duty[k]); end
            n_cmp++; if (busy !== (k < 2)) begin n_err++; $display("FAIL ramp_busy: cycle %0d got %b want %b", cyc, busy, k < 2); end
            n_cmp++; if (at_target !== (k == 2)) begin n_err++; $display("FAIL ramp_at_target: cycle %0d got %b want %b", cyc, at_target, k == 2); end
        end
    endtask

    task automatic test_clamp_tick();
        run_to(499);
        n_cmp++; if (frame_tick !== 1'b1) begin n_err++; $display("FAIL clamp_tick: got %b want 1", frame_tick); end
        n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL clamp_ready: got %b want 1", cmd_ready); end
        cmd_valid = 1'b1; cmd_angle = 8'd200;
        step();
        cmd_angle = 8'd255;
        n_cmp++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL full_ready: got %b want 0", cmd_ready); end
        run_to(599);
        n_cmp++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL full_ready_late: got %b want 0", cmd_ready); end
        n_cmp++; if (duty !== 18'd20) begin n_err++; $display("FAIL tick_accept_delay: got %0d want 20", duty); end
        step();
        n_cmp++; if (duty !== 18'd30) begin n_err++; $display("FAIL clamp_first_step: got %0d want 30", duty); end
        n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL ready_after_transfer: got %b want 1", cmd_ready); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL clamp_busy: got %b want 1", busy); end
        step();
        cmd_valid = 1'b0;
        n_cmp++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL second_accept: got %b want 0", cmd_ready); end
        run_to(1000);
        n_cmp++; if (duty !== 18'd70) begin n_err++; $display("FAIL clamp_mid: got %0d want 70", duty); end
        run_to(1100);
        n_cmp++; if (duty !== 18'd80) begin n_err++; $display("FAIL clamp_final: got %0d want 80", duty); end
        n_cmp++; if (at_target !== 1'b1) begin n_err++; $display("FAIL clamp_at_target: got %b want 1", at_target); end
    endtask

    task automatic test_disable();
        run_to(1101);
        cmd_valid = 1'b1; cmd_angle = 8'd0;
        step();
        cmd_valid = 1'b0;
        run_to(1200);
        n_cmp++; if (duty !== 18'd70) begin n_err++; $display("FAIL dis_ramp1: got %0d want 70", duty); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL dis_busy: got %b want 1", busy); end
        run_to(1350);
        enable = 1'b0;
        run_to(1399);
        n_cmp++; if (duty !== 18'd60) begin n_err++; $display("FAIL dis_wait_tick: got %0d want 60", duty); end
        run_to(1400);
        n_cmp++; if (duty !== '0) begin n_err++; $display("FAIL dis_duty: got %0d want 0", duty); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL dis_off_busy: got %b want 0", busy); end
        n_cmp++; if (at_target !== 1'b0) begin n_err++; $display("FAIL dis_off_at: got %b want 0", at_target); end
        run_to(1450);
        enable = 1'b1;
        run_to(1500);
        n_cmp++; if (duty !== 18'd20) begin n_err++; $display("FAIL reenable_jump: got %0d want 20", duty); end
        n_cmp++; if (at_target !== 1'b1) begin n_err++; $display("FAIL reenable_at: got %b want 1", at_target); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reenable_busy: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid_ramp();
        run_to(1501);
        cmd_valid = 1'b1; cmd_angle = 8'd60;
        step();
        cmd_valid = 1'b0;
        run_to(1700);
        n_cmp++; if (duty !== 18'd40) begin n_err++; $display("FAIL mid_duty: got %0d want 40", duty); end
        run_to(1750);
        cmd_valid = 1'b1; cmd_angle = 8'd10;
        step();
        cmd_valid = 1'b0;
        run_to(1760);
        n_cmp++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL mid_pending: got %b want 0", cmd_ready); end
        rst = 1'b1;
        step();
        n_cmp++; if (duty !== '0) begin n_err++; $display("FAIL mid_rst_duty: got %0d want 0", duty); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
        n_cmp++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL mid_rst_ready: got %b want 0", cmd_ready); end
        rst = 1'b0;
        cyc = 0;
        #1;
        n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL mid_pending_cleared: got %b want 1", cmd_ready); end
        run_to(100);
        n_cmp++; if (duty !== 18'd20) begin n_err++; $display("FAIL mid_target_reset: got %0d want 20", duty); end
        n_cmp++; if (at_target !== 1'b1) begin n_err++; $display("FAIL mid_at_target: got %b want 1", at_target); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 2999) == 0);
            if ($urandom_range(0, 249) == 0) enable = !enable;
            if (!cmd_valid || $urandom_range(0, 3) == 0) begin
                cmd_valid = ($urandom_range(0, 19) == 0);
                case ($urandom_range(0, 4))
                    0:       cmd_angle = 8'd0;
                    1:       cmd_angle = 8'd60;
                    2:       cmd_angle = 8'd255;
                    default: cmd_angle = 8'($urandom_range(0, 255));
                endcase
            end
            step();
            n_cmp++; if (duty !== DUTY_W'(m_duty)) begin n_err++; $display("FAIL rand_duty: iter %0d got %0d want %0d", i, duty, m_duty); end
            n_cmp++; if (cmd_ready !== (!rst && !m_pend_v)) begin n_err++; $display("FAIL rand_ready: iter %0d got %b", i, cmd_ready); end
            n_cmp++; if (frame_tick !== (m_cnt == P - 1)) begin n_err++; $display("FAIL rand_tick: iter %0d got %b", i, frame_tick); end
            n_cmp++; if (busy !== (m_on && m_duty != m_target)) begin n_err++; $display("FAIL rand_busy: iter %0d got %b", i, busy); end
            n_cmp++; if (at_target !== (m_on && m_duty == m_target)) begin n_err++; $display("FAIL rand_at_target: iter %0d got %b", i, at_target); end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_enable();
        test_down_ramp();
        test_clamp_tick();
        test_disable();
        test_reset_mid_ramp();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/servo_ctrl.md
# servo_ctrl

Position controller that sequences the servo PWM generator's `duty` input. It accepts angle commands over a valid/ready handshake and maps each angle to a pulse width. It slews `duty` toward that width by a bounded step per 20 ms frame, and changes `duty` only at frame boundaries, so the PWM never emits a truncated or stretched pulse. It sits between the command source (UART/CPU/sequencer) and the PWM generator. Top level ties the PWM's `rst_n` to `~rst`.

## Interface
- `CLK_IN`, 50_000_000: input clock, Hz
- `FREQ_SERVO`, 50: frame rate, Hz; `TOTAL_PERIOD = CLK_IN/FREQ_SERVO`
- `MIN_PULSE`, 50_000: duty in cycles for angle 0 (1 ms)
- `MAX_PULSE`, 100_000: duty ceiling in cycles (2 ms)
- `LSB_CYCLES`, 196: cycles per angle LSB
- `STEP`, 2_500: maximum duty change per frame, cycles
- `clk`  in  1  system clock
- `rst`  in  1  reset; one clock, reset is synchronous and active-high
- `enable`  in  1  1 = drive servo, 0 = output off (duty 0)
- `cmd_valid`  in  1  angle command valid
- `cmd_ready`  out  1  command slot empty
- `cmd_angle`  in  8  commanded angle code 0..255
- `duty`  out  18  pulse width in cycles, to PWM `duty`
- `frame_tick`  out  1  high for the last cycle of each frame
- `at_target`  out  1  `duty == target`, with state HOLD
- `busy`  out  1  state RAMP

## Operation
- **Frame counter:** 20 bits, counts 0..TOTAL_PERIOD-1 and wraps to 0. `frame_tick = (count == TOTAL_PERIOD-1)`.
- **Angle mapping:** `pos = MIN_PULSE + cmd_angle*LSB_CYCLES`, computed at 18+ bits. If `pos > MAX_PULSE`, `pos = MAX_PULSE`. The mapping is computed on acceptance and stored in `pending`.
- **Handshake:** `cmd_ready = !pending_full` (0 during reset). A command is accepted when `cmd_valid && cmd_ready`.
  - `pending` moves to `target` on the next `frame_tick` strictly after acceptance. An accept on a `frame_tick` cycle waits one full frame.
  - `cmd_ready` returns high the cycle after the transfer tick.
- **States** (evaluated only on `frame_tick` cycles; otherwise hold):
  - **OFF:** `duty = 0`.
    - `enable=1` → HOLD, and `duty <= target`. There is no ramp from unknown mechanical position.
  - **HOLD:**
    - `enable=0` → OFF, `duty <= 0`.
    - Else if the incoming target (the transfer in the same tick takes priority) is not equal to `duty` → RAMP and apply one step.
  - **RAMP:** each tick, `duty <= duty<target ? min(duty+STEP,target) : max(duty-STEP,target)`.
    - Reaching target → HOLD.
    - `enable=0` → OFF, `duty <= 0`.
    - A new target mid-ramp redirects from the current `duty`.
- **Simultaneous tick + transfer + enable change:**
  - Use the new target in the step calculation.
  - `enable=0` wins over everything.
  - `target` still updates.

## Timing
- **Reset values:** `duty=0`, `cmd_ready=0`, `frame_tick=0`, `at_target=0`, `busy=0`, state OFF, `target=MIN_PULSE`, pending empty, count 0.
- **Reset mid-operation:** all of the above on the next edge.
- **After release:** `cmd_ready=1` on the first cycle. The first `frame_tick` is on cycle TOTAL_PERIOD-1.
- **Duty update:** `duty`, state, `at_target` and `busy` are registered. They change on the edge ending the `frame_tick` cycle, coincident with the count returning to 0, so the PWM sharing reset release sees new `duty` from counter 0.
- **Latency:**
  - Accept-to-first-duty-change is at most 2 frames.
  - A full ramp takes `ceil(|Δ|/STEP)` frames.

## Structure
- **`servo_pkg`:**
  - `typedef enum logic [1:0] {OFF, HOLD, RAMP} servo_state_t`
  - `DUTY_W=18`, `CNT_W=20`, `ANGLE_W=8`
  - default timing constants, shared with the PWM generator
- **Sub-module `servo_frame_timer`:** parameterised by TOTAL_PERIOD; outputs `frame_tick`. The rest is `servo_ctrl`.

## Test plan
Overrides: TOTAL_PERIOD=100 (CLK_IN=1000, FREQ_SERVO=10), MIN_PULSE=20, MAX_PULSE=80, LSB_CYCLES=1, STEP=10.
- **Reset:** `rst` held 3 cycles → all outputs 0 during reset. `cmd_ready=1` on the cycle after release; `frame_tick` at cycle 99, 199.
- **First enable:** `enable=1`, angle 30 accepted at cycle 5 → target=50 at tick 99. `duty=50` from cycle 100, `at_target=1`, `busy=0`.
- **Downward ramp:** then angle 0 → `duty` 50→40→30→20 at successive ticks. `busy=1` until `duty=20`, then `at_target=1`.
- **Clamp and accept on tick:** angle 200 → pos 220 clamps, `duty` ramps to 80. A command accepted on a tick cycle takes effect one frame later. A second `cmd_valid` while pending full sees `cmd_ready=0` until the cycle after transfer.
- **Disable mid-ramp:** `enable=0` mid-ramp → `duty=0` after next tick, state OFF. Re-enable → jump to target.
- **Reset mid-ramp:** `rst` mid-ramp at `duty=40` → `duty=0`, pending cleared, target=20 next edge.
